clk_freq_monitor: RTL and testbench



---
 rtl/clk_freq_monitor_if.sv | 36 +++
 rtl/clk_freq_monitor.sv | 171 +++++++++++++++++
 tb/tb_clk_freq_monitor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_freq_monitor_if.sv
// Signal bundle between clk_freq_monitor and its environment.
// With STICKY_ERR_EN defined the bundle also carries clr_err and sticky_err.
interface clk_freq_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             mon_toggle;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             too_fast;
    logic             too_slow;
    logic             freq_ok;
    logic             fault_rst;
`ifdef STICKY_ERR_EN
    logic             clr_err;
    logic             sticky_err;

    modport master (
        output enable, mon_toggle, clr_err,
        input  meas_cnt, meas_valid, too_fast, too_slow, freq_ok, fault_rst, sticky_err
    );
    modport slave (
        input  enable, mon_toggle, clr_err,
        output meas_cnt, meas_valid, too_fast, too_slow, freq_ok, fault_rst, sticky_err
    );
`else
    modport master (
        output enable, mon_toggle,
        input  meas_cnt, meas_valid, too_fast, too_slow, freq_ok, fault_rst
    );
    modport slave (
        input  enable, mon_toggle,
        output meas_cnt, meas_valid, too_fast, too_slow, freq_ok, fault_rst
    );
`endif
endinterface

// File: rtl/clk_freq_monitor.sv
// Windowed edge-count frequency monitor with lock/unlock debounce FSM.
// Optional macro STICKY_ERR_EN adds a sticky loss-of-lock flag (sticky_err/clr_err).
module clk_freq_monitor #(
    parameter int WIN_CYCLES = 1000,
    parameter int EXP_CNT    = 250,
    parameter int TOL        = 5,
    parameter int CNT_W      = 16,
    parameter int GOOD_WINS  = 4,
    parameter int BAD_WINS   = 2
) (
    input  logic               clkin_50M,
    input  logic               reset_n,
    clk_freq_monitor_if.slave  mon
);
    localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int GC_W  = $clog2(GOOD_WINS + 1);
    localparam int BC_W  = $clog2(BAD_WINS + 1);
    // Lower bound clamps at zero so a tolerance wider than the target never wraps.
    localparam int LO_I  = (EXP_CNT > TOL) ? EXP_CNT - TOL : 0;
    localparam int HI_I  = EXP_CNT + TOL;
    localparam logic [CNT_W:0]   LO       = (CNT_W+1)'(LO_I);
    localparam logic [CNT_W:0]   HI       = (CNT_W+1)'(HI_I);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    typedef enum logic [1:0] {UNLOCKED, CHECKING, LOCKED, DEGRADED} state_t;

    logic             s1, s2, s3;
    logic             edge_det;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             win_end;
    logic             fast, slow, good;
    state_t           state;
    logic [GC_W-1:0]  good_cnt;
    logic [BC_W-1:0]  bad_cnt;

    assign edge_det = s2 ^ s3;
    assign win_end  = mon.enable && (win_cnt == WIN_LAST);
    assign cnt_next = (&edge_cnt) ? edge_cnt : edge_cnt + CNT_W'(edge_det);
    assign fast     = {1'b0, cnt_next} > HI;
    assign slow     = {1'b0, cnt_next} < LO;
    assign good     = !fast && !slow;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clkin_50M or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon.mon_toggle;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clkin_50M or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (!mon.enable || win_end) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clkin_50M or negedge reset_n) begin
        if (!reset_n) begin
            mon.meas_cnt   <= '0;
            mon.meas_valid <= 1'b0;
            mon.too_fast   <= 1'b0;
            mon.too_slow   <= 1'b0;
        end else begin
            mon.meas_valid <= win_end;
            if (win_end) begin
                mon.meas_cnt <= cnt_next;
                mon.too_fast <= fast;
                mon.too_slow <= slow;
            end
        end
    end

    // Lock debounce; freq_ok/fault_rst are registered alongside the state they reflect.
    always_ff @(posedge clkin_50M or negedge reset_n) begin
        if (!reset_n) begin
            state         <= UNLOCKED;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            mon.freq_ok   <= 1'b0;
            mon.fault_rst <= 1'b1;
        end else if (win_end) begin
            case (state)
                UNLOCKED: begin
                    if (good) begin
                        if (GOOD_WINS == 1) begin
                            state         <= LOCKED;
                            mon.freq_ok   <= 1'b1;
                            mon.fault_rst <= 1'b0;
                        end else begin
                            state    <= CHECKING;
                            good_cnt <= GC_W'(1);
                        end
                    end
                end
                CHECKING: begin
                    if (!good) begin
                        state    <= UNLOCKED;
                        good_cnt <= '0;
                    end else if (int'(good_cnt) + 1 >= GOOD_WINS) begin
                        state         <= LOCKED;
                        good_cnt      <= '0;
                        mon.freq_ok   <= 1'b1;
                        mon.fault_rst <= 1'b0;
                    end else begin
                        good_cnt <= good_cnt + GC_W'(1);
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        if (BAD_WINS == 1) begin
                            state         <= UNLOCKED;
                            mon.freq_ok   <= 1'b0;
                            mon.fault_rst <= 1'b1;
                        end else begin
                            state   <= DEGRADED;
                            bad_cnt <= BC_W'(1);
                        end
                    end
                end
                DEGRADED: begin
                    if (good) begin
                        state   <= LOCKED;
                        bad_cnt <= '0;
                    end else if (int'(bad_cnt) + 1 >= BAD_WINS) begin
                        state         <= UNLOCKED;
                        bad_cnt       <= '0;
                        mon.freq_ok   <= 1'b0;
                        mon.fault_rst <= 1'b1;
                    end else begin
                        bad_cnt <= bad_cnt + BC_W'(1);
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

`ifdef STICKY_ERR_EN
    logic drop_lock;

    assign drop_lock = win_end && !good &&
                       ((state == LOCKED && BAD_WINS == 1) ||
                        (state == DEGRADED && int'(bad_cnt) + 1 >= BAD_WINS));

    // Setting has priority so a loss of lock is never lost to a simultaneous clear.
    always_ff @(posedge clkin_50M or negedge reset_n) begin
        if (!reset_n) begin
            mon.sticky_err <= 1'b0;
        end else if (drop_lock) begin
            mon.sticky_err <= 1'b1;
        end else if (mon.clr_err) begin
            mon.sticky_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor: streak-based reference model plus
// directed window-level expectations.
module tb_clk_freq_monitor;
    localparam int WIN  = 1000;
    localparam int EXPC = 250;
    localparam int TOLC = 5;
    localparam int GOODW = 4;
    localparam int BADW  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    clk_freq_monitor_if #(.CNT_W(16)) mif ();

    clk_freq_monitor #(
        .WIN_CYCLES(WIN), .EXP_CNT(EXPC), .TOL(TOLC),
        .CNT_W(16), .GOOD_WINS(GOODW), .BAD_WINS(BADW)
    ) dut (
        .clkin_50M (clk),
        .reset_n   (reset_n),
        .mon       (mif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges are input transitions seen three samples late,
    // counted per enabled window; lock judged by good/bad streak lengths.
    bit [3:0] h = '0;
    int  m_wc = 0, m_ec = 0, gs = 0, bs = 0, e_cnt = 0;
    bit  e_valid = 0, e_fast = 0, e_slow = 0, e_ok = 0, e_sticky = 0;

    always @(posedge clk or negedge reset_n) begin
        bit drop;
        if (!reset_n) begin
            h = '0; m_wc = 0; m_ec = 0; gs = 0; bs = 0; e_cnt = 0;
            e_valid = 0; e_fast = 0; e_slow = 0; e_ok = 0; e_sticky = 0;
        end else begin
            drop = 0;
            h = {h[2:0], mif.mon_toggle};
            e_valid = 0;
            if (!mif.enable) begin
                m_wc = 0;
                m_ec = 0;
            end else begin
                if (m_ec < 65535) m_ec = m_ec + int'(h[2] ^ h[3]);
                m_wc++;
                if (m_wc == WIN) begin
                    e_valid = 1;
                    e_cnt   = m_ec;
                    e_fast  = (m_ec > EXPC + TOLC);
                    e_slow  = (m_ec < EXPC - TOLC);
                    if (!e_ok) begin
                        gs = (!e_fast && !e_slow) ? gs + 1 : 0;
                        if (gs >= GOODW) begin e_ok = 1; gs = 0; end
                        bs = 0;
                    end else begin
                        bs = (!e_fast && !e_slow) ? 0 : bs + 1;
                        if (bs >= BADW) begin e_ok = 0; bs = 0; drop = 1; end
                    end
                    m_wc = 0;
                    m_ec = 0;
                end
            end
`ifdef STICKY_ERR_EN
            if (drop) e_sticky = 1;
            else if (mif.clr_err) e_sticky = 0;
`endif
        end
    end

    always @(negedge clk) begin
        check("meas_valid", mif.meas_valid, e_valid);
        check("meas_cnt",   mif.meas_cnt,   e_cnt);
        check("too_fast",   mif.too_fast,   e_fast);
        check("too_slow",   mif.too_slow,   e_slow);
        check("freq_ok",    mif.freq_ok,    e_ok);
        check("fault_rst",  mif.fault_rst,  !e_ok);
`ifdef STICKY_ERR_EN
        check("sticky_err", mif.sticky_err, e_sticky);
`endif
    end

    // Toggle generator: free-running period, or a burst of edges placed early in each window.
    int gcyc = 0, fpos = 0, period = 0, burst = 0;

    task automatic step();
        bit tog_now;
        tog_now = 0;
        if (period != 0) tog_now = (gcyc % period == 0);
        else if (mif.enable && burst > 0 && fpos >= 10 &&
                 (fpos - 10) % 3 == 0 && (fpos - 10) / 3 < burst) tog_now = 1;
        if (tog_now) mif.mon_toggle = ~mif.mon_toggle;
        gcyc++;
        fpos = mif.enable ? (fpos + 1) % WIN : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!mif.meas_valid && cyc < WIN + 100);
        check("valid_seen", mif.meas_valid, 1'b1);
    endtask

    task automatic expect_win(string tag, int cnt, bit fast, bit slow, bit ok, output int cyc);
        wait_valid(cyc);
        if (cnt >= 0) check({tag, "_cnt"}, mif.meas_cnt, cnt);
        check({tag, "_fast"},  mif.too_fast,  fast);
        check({tag, "_slow"},  mif.too_slow,  slow);
        check({tag, "_ok"},    mif.freq_ok,   ok);
        check({tag, "_fault"}, mif.fault_rst, !ok);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nv;
        mif.enable = 1'b0;
        mif.mon_toggle = 1'b0;
`ifdef STICKY_ERR_EN
        mif.clr_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_meas_cnt",  mif.meas_cnt,   0);
        check("rst_valid",     mif.meas_valid, 0);
        check("rst_fast",      mif.too_fast,   0);
        check("rst_slow",      mif.too_slow,   0);
        check("rst_ok",        mif.freq_ok,    0);
        check("rst_fault",     mif.fault_rst,  1);
        #2 reset_n = 1'b1;

        // Nominal 250 edges/window: lock on the 4th result, first result after 1000 cycles.
        period = 4;
        repeat (20) step();
        mif.enable = 1'b1;
        fpos = 0;
        expect_win("t1_w1", 250, 0, 0, 0, cyc);
        check("t1_latency", cyc, 1000);
        expect_win("t1_w2", 250, 0, 0, 0, cyc);
        expect_win("t1_w3", 250, 0, 0, 0, cyc);
        expect_win("t1_w4", 250, 0, 0, 1, cyc);
        period = 0;
        burst = 250;
        expect_win("t1_w5", -1, 0, 0, 1, cyc);

        // Toggle stops: hold lock through one bad window, drop on the second.
        burst = 0;
        expect_win("t3_b1", 0, 0, 1, 1, cyc);
        expect_win("t3_b2", 0, 0, 1, 0, cyc);
`ifdef STICKY_ERR_EN
        check("t3_sticky_set", mif.sticky_err, 1);
        repeat (5) step();
        check("t3_sticky_hold", mif.sticky_err, 1);
        mif.clr_err = 1'b1;
        step();
        mif.clr_err = 1'b0;
        check("t3_sticky_clr", mif.sticky_err, 0);
`endif

        // Too fast, then tolerance edges 245/255 good and 244/256 bad.
        period = 3;
        expect_win("t2_f1", -1, 1, 0, 0, cyc);
        expect_win("t2_f2", -1, 1, 0, 0, cyc);
        check("t2_f2_range", (mif.meas_cnt >= 333 && mif.meas_cnt <= 334), 1);
        period = 0;
        burst = 245;
        expect_win("t2_pre", -1, 0, 0, 0, cyc);
        expect_win("t2_245", 245, 0, 0, 0, cyc);
        burst = 255;
        expect_win("t2_255", 255, 0, 0, 0, cyc);
        burst = 244;
        expect_win("t2_244", 244, 0, 1, 0, cyc);
        burst = 256;
        expect_win("t2_256", 256, 1, 0, 0, cyc);

        // Relock, then isolated bad windows never drop lock.
        burst = 250;
        expect_win("t4_g1", 250, 0, 0, 0, cyc);
        expect_win("t4_g2", 250, 0, 0, 0, cyc);
        expect_win("t4_g3", 250, 0, 0, 0, cyc);
        expect_win("t4_g4", 250, 0, 0, 1, cyc);
        burst = 200;
        expect_win("t4_bad1", 200, 0, 1, 1, cyc);
        burst = 250;
        expect_win("t4_good1", 250, 0, 0, 1, cyc);
        burst = 200;
        expect_win("t4_bad2", 200, 0, 1, 1, cyc);
        burst = 250;
        expect_win("t4_good2", 250, 0, 0, 1, cyc);

        // Enable gap at window cycle 500 discards the partial window.
        repeat (500) step();
        mif.enable = 1'b0;
        nv = 0;
        repeat (20) begin
            step();
            if (mif.meas_valid) nv++;
        end
        check("t5_no_valid", nv, 0);
        mif.enable = 1'b1;
        fpos = 0;
        expect_win("t5_resume", 250, 0, 0, 1, cyc);
        check("t5_latency", cyc, 1000);

        // Asynchronous reset mid-window while locked, then a full relock.
        repeat (300) step();
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_cnt",   mif.meas_cnt,   0);
        check("t6_rst_valid", mif.meas_valid, 0);
        check("t6_rst_slow",  mif.too_slow,   0);
        check("t6_rst_ok",    mif.freq_ok,    0);
        check("t6_rst_fault", mif.fault_rst,  1);
        repeat (3) step();
        #2 reset_n = 1'b1;
        fpos = 0;
        expect_win("t6_w1", -1, 0, 0, 0, cyc);
        check("t6_latency", cyc, 1000);
        expect_win("t6_w2", 250, 0, 0, 0, cyc);
        expect_win("t6_w3", 250, 0, 0, 0, cyc);
        expect_win("t6_w4", 250, 0, 0, 1, cyc);

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
